// File: rtl/ahb_regbank_slave.sv
// ahb_regbank_slave
// AHB-Lite slave holding a 16 x 32-bit register bank. Word 15 is a read-only
// identification constant. Each OKAY transfer can be stretched by a fixed
// number of data-phase wait cycles. Misaligned or oversized transfers get the
// two-cycle ERROR response and never touch storage.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   HSEL       slave select
//   HADDR      byte address, only [5:0] decoded (upper bits alias)
//   HTRANS     IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   HWRITE     1=write, 0=read
//   HSIZE      000 byte, 001 halfword, 010 word
//   HWDATA     write data, valid in the data phase
//   HREADY     bus-level ready (previous transfer complete)
//   HRDATA     read data, zero outside a read data phase
//   HREADYOUT  slave ready
//   HRESP      0=OKAY, 1=ERROR
//
// state | meaning
// IDLE  | no data phase in progress
// WAIT  | OKAY transfer stretched, wait_cnt_q counts down to 0
// DATA  | final data-phase cycle, write commits / read data driven
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb_regbank_slave #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q;
  logic [5:0]  addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic [31:0] regs [16];

  logic        can_accept;
  logic        accept;
  logic        illegal;
  logic        commit;
  logic [3:0]  byte_en;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:6], HTRANS[0]};

  // A new address phase is only taken while our own HREADYOUT is high, so the
  // latched transfer is frozen during WAIT and ERR1.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept && HSEL && HTRANS[1] && HREADY;

  assign illegal = (HSIZE > 3'b010) ||
                   ((HSIZE == 3'b001) && HADDR[0]) ||
                   ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

  // Word 15 is the ID constant; writes to it complete OKAY but are dropped.
  assign commit  = (state_q == ST_DATA) && write_q && (addr_q[5:2] != 4'd15);
  assign rd_word = (addr_q[5:2] == 4'd15) ? ID_VALUE : regs[addr_q[5:2]];

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      3'b000:  byte_en = 4'b0001 << addr_q[1:0];
      3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // State register plus latched address-phase information.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
      addr_q     <= 6'd0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= HADDR[5:0];
        write_q    <= HWRITE;
        size_q     <= HSIZE;
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == ST_WAIT) && (wait_cnt_q != 2'd0)) begin
        wait_cnt_q <= wait_cnt_q - 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (illegal)              state_d = ST_ERR1;
          else if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                      state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: if (!write_q) HRDATA = rd_word;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // Byte lanes are taken straight from HWDATA (little-endian, unshifted).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) regs[addr_q[5:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_regbank_slave.sv
module tb_ahb_regbank_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        hready_gate;
  logic        tgt;
  logic        hready_bus;

  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;
  logic        cur_ro, cur_resp;
  logic [31:0] cur_rdata;

  typedef struct {
    string       tag;
    logic        err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acc_cnt  = 0;
  bit   dp_active = 1'b0;
  int   waits = 0;

  always #5 clk = ~clk;

  assign hready_bus = (tgt ? hreadyout1 : hreadyout0) & hready_gate;
  assign cur_ro     = tgt ? hreadyout1 : hreadyout0;
  assign cur_resp   = tgt ? hresp1 : hresp0;
  assign cur_rdata  = tgt ? hrdata1 : hrdata0;

  ahb_regbank_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(HSEL & ~tgt), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready_bus),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb_regbank_slave #(.WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(reset), .HSEL(HSEL & tgt), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready_bus),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: data phases are tracked 2 time units after each falling
  // edge, when the inputs for the coming rising edge are already stable.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      exp_q.delete();
      dp_active = 1'b0;
      waits = 0;
    end else begin
      if (dp_active) begin
        if (cur_ro) begin
          chk("scoreboard_depth", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_resp"}, 32'(cur_resp), 32'(e.err));
            chk({e.tag, "_rdata"}, cur_rdata, e.rdata);
            chk({e.tag, "_waits"}, waits, e.waits);
          end
          dp_active = 1'b0;
        end else begin
          waits++;
          if (exp_q.size() > 0) chk({exp_q[0].tag, "_stall_resp"}, 32'(cur_resp), 32'(exp_q[0].err));
        end
      end else begin
        chk("idle_ready", 32'(cur_ro), 32'd1);
        chk("idle_resp", 32'(cur_resp), 32'd0);
        chk("idle_rdata", cur_rdata, 32'd0);
      end
      if (HSEL && HTRANS[1] && hready_bus) begin
        dp_active = 1'b1;
        waits = 0;
        acc_cnt++;
      end
    end
  end

  // Called at falling edge + 1; returns at falling edge + 1 of the data phase.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input string tag);
    exp_t e;
    int   n;
    int   guard;
    e.tag   = tag;
    e.err   = err;
    e.waits = err ? 1 : (tgt ? 2 : 0);
    e.rdata = rdata;
    HSEL   = 1'b1;
    HADDR  = addr;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = size;
    exp_q.push_back(e);
    n = acc_cnt;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while ((acc_cnt == n) && (guard < 20));
    chk({tag, "_accepted"}, acc_cnt, n + 1);
    HWDATA = wdata;
  endtask

  task automatic go_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic drain();
    int guard = 0;
    while (((exp_q.size() != 0) || dp_active) && (guard < 30)) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; hready_gate = 1'b1; tgt = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(hreadyout0), 32'd1);
    chk("rst_resp0", 32'(hresp0), 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ready1", 32'(hreadyout1), 32'd1);
    chk("rst_resp1", 32'(hresp1), 32'd0);
    chk("rst_rdata1", hrdata1, 32'd0);
    reset = 1'b0;

    // zero-wait slave
    issue(1, 32'h08, 3'b010, 32'hDEADBEEF, 0, 32'h0, "w08");
    issue(0, 32'h08, 3'b010, 32'h0, 0, 32'hDEADBEEF, "r08");
    issue(1, 32'h0D, 3'b000, 32'h00005A00, 0, 32'h0, "wb0d");
    issue(0, 32'h0C, 3'b010, 32'h0, 0, 32'h00005A00, "r0c");
    issue(1, 32'h04, 3'b010, 32'h11223344, 0, 32'h0, "w04");
    issue(1, 32'h06, 3'b010, 32'hFFFFFFFF, 1, 32'h0, "w06_err");
    issue(0, 32'h04, 3'b010, 32'h0, 0, 32'h11223344, "r04");
    issue(1, 32'h10, 3'b010, 32'hCAFEF00D, 0, 32'h0, "w10");
    issue(1, 32'h12, 3'b001, 32'h12340000, 0, 32'h0, "wh12");
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'h1234F00D, "r10_a");
    issue(1, 32'h11, 3'b001, 32'hFFFFFFFF, 1, 32'h0, "wh11_err");
    issue(1, 32'h10, 3'b011, 32'hFFFFFFFF, 1, 32'h0, "size3_err");
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'h1234F00D, "r10_b");
    issue(1, 32'h13, 3'b000, 32'h77000000, 0, 32'h0, "wb13");
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'h7734F00D, "r10_c");
    issue(1, 32'h54, 3'b010, 32'h0BADCAFE, 0, 32'h0, "w54_alias");
    issue(0, 32'h14, 3'b010, 32'h0, 0, 32'h0BADCAFE, "r14");
    issue(0, 32'hFFFFFFD4, 3'b010, 32'h0, 0, 32'h0BADCAFE, "rd4_alias");
    issue(0, 32'h3C, 3'b010, 32'h0, 0, 32'hA5B00001, "r3c_id");
    issue(1, 32'h3C, 3'b010, 32'h00000001, 0, 32'h0, "w3c_ro");
    issue(0, 32'h3C, 3'b010, 32'h0, 0, 32'hA5B00001, "r3c_id2");
    issue(0, 32'h0A, 3'b001, 32'h0, 0, 32'hDEADBEEF, "rh0a");
    go_idle();
    drain();

    // bus held not-ready by another slave: no acceptance until HREADY rises
    hready_gate = 1'b0;
    HSEL = 1'b1; HADDR = 32'h0C; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010;
    exp_q.push_back('{tag: "r0c_stall", err: 1'b0, waits: 0, rdata: 32'h00005A00});
    n = acc_cnt;
    repeat (3) begin @(negedge clk); #1; end
    chk("stall_no_accept", acc_cnt, n);
    hready_gate = 1'b1;
    @(negedge clk); #1;
    chk("stall_accept", acc_cnt, n + 1);
    go_idle();
    drain();

    // two-wait-state slave
    tgt = 1'b1;
    @(negedge clk); #1;
    issue(1, 32'h3C, 3'b010, 32'h00000001, 0, 32'h0, "ws_w3c");
    issue(0, 32'h3C, 3'b010, 32'h0, 0, 32'hA5B00001, "ws_r3c");
    issue(1, 32'h20, 3'b010, 32'h600DF00D, 0, 32'h0, "ws_w20");
    issue(1, 32'h22, 3'b010, 32'hFFFFFFFF, 1, 32'h0, "ws_w22_err");
    issue(0, 32'h20, 3'b010, 32'h0, 0, 32'h600DF00D, "ws_r20");
    go_idle();
    drain();

    // reset in the middle of a stretched write
    issue(1, 32'h00, 3'b010, 32'h12345678, 0, 32'h0, "ws_w00_abort");
    chk("abort_in_wait", 32'(hreadyout1), 32'd0);
    reset = 1'b1;
    go_idle();
    @(negedge clk); #1;
    chk("abort_ready", 32'(hreadyout1), 32'd1);
    chk("abort_resp", 32'(hresp1), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    issue(0, 32'h00, 3'b010, 32'h0, 0, 32'h0, "ws_r00");
    issue(0, 32'h20, 3'b010, 32'h0, 0, 32'h0, "ws_r20_rst");
    go_idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
